// File: rtl/game_level_controller_pkg.sv
// Shared definitions for the whack-a-mole level sequencer: state encoding,
// per-level mole speed table and default game tuning.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int SPEED_W = 28;

  // Mole visible time per level, in clock cycles at 50 MHz (2.0/1.5/1.0/0.5 s).
  localparam logic [SPEED_W-1:0] SPEED_TABLE [4] = '{
    28'd99999999, 28'd74999999, 28'd49999999, 28'd24999999
  };

  localparam int DEF_LEVEL_HITS   = 8;
  localparam int DEF_MAX_LIVES    = 5;
  localparam int DEF_PAUSE_CYCLES = 100000000;

  function automatic logic [SPEED_W-1:0] speed_for(input logic [1:0] lvl);
    return SPEED_TABLE[lvl];
  endfunction

endpackage

// File: rtl/game_level_controller_if.sv
// Player inputs and game status outputs of the level sequencer; the game
// logic drives the master side, the level controller implements the slave.
interface game_level_if;
  import game_pkg::*;

  logic               start;
  logic               hit;
  logic               miss;
  logic               game;
  logic [SPEED_W-1:0] speed;
  logic [1:0]         level;
  logic [2:0]         lives;
  logic               game_over;
  logic               won;
  logic [1:0]         state;

  modport master (
    output start, hit, miss,
    input  game, speed, level, lives, game_over, won, state
  );

  modport slave (
    input  start, hit, miss,
    output game, speed, level, lives, game_over, won, state
  );
endinterface

// File: rtl/level_pause_timer.sv
// Down-counter timing the pause between levels: load arms it, enable counts
// it down, done is asserted for the cycle the count reaches zero.
module level_pause_timer #(
  parameter int               WIDTH      = 28,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= LOAD_VALUE;
    else if (enable && count != '0)
      count <= count - 1'b1;
  end

  assign done = enable && !load && (count == '0);

endmodule

// File: rtl/game_level_controller.sv
// Top-level game sequencer: tracks hits, misses and lives, steps through four
// difficulty levels with a pause between them, and ends on a win or loss.
module game_level_controller
  import game_pkg::*;
#(
  parameter int                 LEVEL_HITS   = DEF_LEVEL_HITS,
  parameter int                 MAX_LIVES    = DEF_MAX_LIVES,
  parameter int                 PAUSE_CYCLES = DEF_PAUSE_CYCLES,
  parameter logic [SPEED_W-1:0] SPEED_L0     = SPEED_TABLE[0]
) (
  input  logic        clock,
  input  logic        reset,
  game_level_if.slave bus
);

  localparam int              HIT_W      = $clog2(LEVEL_HITS + 1);
  localparam logic [HIT_W-1:0] LAST_HIT  = HIT_W'(LEVEL_HITS - 1);
  localparam logic [2:0]      LIVES_INIT = 3'(MAX_LIVES);

  state_t             state;
  logic               start_q;
  logic [HIT_W-1:0]   hit_cnt;
  logic               game;
  logic [SPEED_W-1:0] speed;
  logic [1:0]         level;
  logic [2:0]         lives;
  logic               game_over;
  logic               won;

  logic start_rise;
  logic fatal_miss;
  logic last_hit;
  logic level_up;
  logic pause_done;

  assign start_rise = bus.start & ~start_q;
  assign fatal_miss = bus.miss && (lives == 3'd1);
  assign last_hit   = bus.hit && (hit_cnt == LAST_HIT);
  // A fatal miss in the same cycle as the clearing hit wins: no level-up.
  assign level_up   = (state == ST_PLAY) && last_hit && !fatal_miss && (level != 2'd3);

  level_pause_timer #(
    .WIDTH      (SPEED_W),
    .LOAD_VALUE (SPEED_W'(PAUSE_CYCLES - 1))
  ) u_pause_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (level_up),
    .enable (state == ST_PAUSE),
    .done   (pause_done)
  );

  always_ff @(posedge clock) begin
    // NOTE: all state uses non-blocking assignments so every branch sees the
    // pre-edge values of lives/level/hit_cnt, matching the "before" semantics.
    if (reset) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      hit_cnt   <= '0;
      game      <= 1'b0;
      speed     <= SPEED_L0;
      level     <= 2'd0;
      lives     <= LIVES_INIT;
      game_over <= 1'b0;
      won       <= 1'b0;
    end else begin
      start_q <= bus.start;
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state     <= ST_PLAY;
            game      <= 1'b1;
            level     <= 2'd0;
            lives     <= LIVES_INIT;
            hit_cnt   <= '0;
            speed     <= SPEED_L0;
            game_over <= 1'b0;
            won       <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (bus.miss)
            lives <= (lives != 3'd0) ? lives - 3'd1 : 3'd0;
          if (fatal_miss) begin
            state     <= ST_OVER;
            game      <= 1'b0;
            game_over <= 1'b1;
            won       <= 1'b0;
          end else if (last_hit) begin
            if (level == 2'd3) begin
              state     <= ST_OVER;
              game      <= 1'b0;
              game_over <= 1'b1;
              won       <= 1'b1;
            end else begin
              state   <= ST_PAUSE;
              level   <= level + 2'd1;
              hit_cnt <= '0;
              speed   <= speed_for(level + 2'd1);
            end
          end else if (bus.hit) begin
            hit_cnt <= hit_cnt + HIT_W'(1);
          end
        end
        ST_PAUSE: begin
          if (pause_done)
            state <= ST_PLAY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.state     = state;
  assign bus.game      = game;
  assign bus.speed     = speed;
  assign bus.level     = level;
  assign bus.lives     = lives;
  assign bus.game_over = game_over;
  assign bus.won       = won;

endmodule
